cpu_trace_monitor: RTL and testbench



---
 rtl/cpu_trace_monitor.sv | 130 +++++++++++++
 tb/tb_cpu_trace_monitor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cpu_trace_monitor.sv
// Instruction trace capture: records {pc, opcode, cycle delta} per opcode fetch into a
// show-ahead FIFO, stopping on a halt opcode or a same-PC loop.
module cpu_trace_monitor #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter int                CNT_W      = 16,
  parameter int                DEPTH      = 16,
  parameter logic [DATA_W-1:0] HALT_OP    = 8'hff,
  parameter int                LOOP_LIMIT = 1
) (
  input  logic                     clk,
  input  logic                     rst_x,
  input  logic                     i_enable,
  input  logic                     i_clear,
  input  logic                     i_sync,
  input  logic [ADDR_W-1:0]        i_ab,
  input  logic [DATA_W-1:0]        i_db,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [ADDR_W-1:0]        o_pc,
  output logic [DATA_W-1:0]        o_opcode,
  output logic [CNT_W-1:0]         o_delta,
  output logic [CNT_W-1:0]         o_cycle,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic                     o_halt,
  output logic                     o_loop
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] opcode;
    logic [CNT_W-1:0]  delta;
  } entry_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  r_cycle, r_last_cycle;
  logic [ADDR_W-1:0] r_last_pc;
  logic [31:0]       r_repeat, repeat_nxt;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level;
  logic              r_overflow, r_halt, r_loop;
  entry_t            mem [DEPTH];
  entry_t            entry, head;
  logic              decode, same_pc, halt_hit, loop_hit, full, pop, push_ok;

  always_comb begin
    decode     = i_enable & i_sync & (state != HALTED);
    same_pc    = (state == RUN) && (i_ab == r_last_pc);
    repeat_nxt = same_pc ? r_repeat + 32'd1 : 32'd0;
    loop_hit   = decode & same_pc & (repeat_nxt >= 32'(LOOP_LIMIT));
    halt_hit   = decode & (i_db == HALT_OP);
    full       = (level == (AW+1)'(DEPTH));
    pop        = (level != '0) & i_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    push_ok    = decode & (~full | pop);
    entry      = '{pc: i_ab, opcode: i_db, delta: r_cycle - r_last_cycle};
  end

  always_comb begin
    state_nxt = state;
    if (i_clear)                          state_nxt = IDLE;
    else if (decode && (halt_hit || loop_hit)) state_nxt = HALTED;
    else if (decode)                      state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state        <= IDLE;
      r_cycle      <= '0;
      r_last_cycle <= '0;
      r_last_pc    <= '0;
      r_repeat     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      r_overflow   <= 1'b0;
      r_halt       <= 1'b0;
      r_loop       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (i_enable) r_cycle <= r_cycle + CNT_W'(1);
      if (i_clear) begin
        r_last_cycle <= '0;
        r_last_pc    <= '0;
        r_repeat     <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        level        <= '0;
        r_overflow   <= 1'b0;
        r_halt       <= 1'b0;
        r_loop       <= 1'b0;
      end else begin
        if (decode) begin
          r_last_cycle <= r_cycle;
          r_last_pc    <= i_ab;
          r_repeat     <= repeat_nxt;
          if (halt_hit) r_halt     <= 1'b1;
          if (loop_hit) r_loop     <= 1'b1;
          if (!push_ok) r_overflow <= 1'b1;
        end
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        case ({push_ok, pop})
          2'b10:   level <= level + (AW+1)'(1);
          2'b01:   level <= level - (AW+1)'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // storage needs no reset; reads are masked by o_valid
  always_ff @(posedge clk) begin
    if (!i_clear && push_ok) mem[wr_ptr] <= entry;
  end

  assign head       = mem[rd_ptr];
  assign o_valid    = (level != '0);
  assign o_pc       = o_valid ? head.pc     : '0;
  assign o_opcode   = o_valid ? head.opcode : '0;
  assign o_delta    = o_valid ? head.delta  : '0;
  assign o_cycle    = r_cycle;
  assign o_level    = level;
  assign o_overflow = r_overflow;
  assign o_halt     = r_halt;
  assign o_loop     = r_loop;
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: spacing, overflow, loop, halt/clear, enable gap, reset.
module tb_cpu_trace_monitor;
  logic        clk, rst_x, i_enable, i_clear, i_sync, i_ready;
  logic [15:0] i_ab;
  logic [7:0]  i_db;
  logic        o_valid, o_overflow, o_halt, o_loop;
  logic [15:0] o_pc, o_delta, o_cycle;
  logic [7:0]  o_opcode;
  logic [4:0]  o_level;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_d;

  cpu_trace_monitor dut (
    .clk(clk), .rst_x(rst_x), .i_enable(i_enable), .i_clear(i_clear), .i_sync(i_sync),
    .i_ab(i_ab), .i_db(i_db), .i_ready(i_ready), .o_valid(o_valid), .o_pc(o_pc),
    .o_opcode(o_opcode), .o_delta(o_delta), .o_cycle(o_cycle), .o_level(o_level),
    .o_overflow(o_overflow), .o_halt(o_halt), .o_loop(o_loop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; the cycle model follows the enable seen at the edge
  task automatic tick();
    @(posedge clk);
    if (rst_x && i_enable) cyc++;
    #1;
  endtask

  initial begin
    rst_x = 1'b0; i_enable = 1'b0; i_clear = 1'b0; i_sync = 1'b0;
    i_ready = 1'b0; i_ab = '0; i_db = '0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_level", o_level, 0);
    chk("rst_flags", {o_overflow, o_halt, o_loop}, 0);
    chk("rst_head",  {o_pc, o_opcode, o_delta}, 0);
    chk("rst_cycle", o_cycle, 0);
    #2 rst_x = 1'b1; i_enable = 1'b1; i_ready = 1'b1;

    // decode spacing 2/2/3 with an eager consumer
    tick(); tick();
    i_sync = 1; i_ab = 16'h0000; i_db = 8'ha9; tick();
    chk("e1_pc", o_pc, 16'h0000); chk("e1_op", o_opcode, 8'ha9);
    chk("e1_delta", o_delta, 2); chk("e1_level", o_level, 1);
    i_sync = 0; tick();
    chk("e1_popped", o_level, 0);
    i_sync = 1; i_ab = 16'h0002; i_db = 8'h85; tick();
    chk("e2_pc", o_pc, 16'h0002); chk("e2_op", o_opcode, 8'h85);
    chk("e2_delta", o_delta, 2); chk("e2_level", o_level, 1);
    i_sync = 0; tick(); tick();
    chk("e2_popped", o_level, 0);
    i_sync = 1; i_ab = 16'h0004; i_db = 8'hea; tick();
    chk("e3_pc", o_pc, 16'h0004); chk("e3_delta", o_delta, 3); chk("e3_level", o_level, 1);
    i_sync = 0; tick();
    chk("e3_popped", o_valid, 0);
    chk("cycle9", o_cycle, 9);

    // fill to full, push+pop at full, then drop one
    i_ready = 0; i_sync = 1;
    for (int i = 0; i < 16; i++) begin
      i_ab = 16'h0100 + 16'(i); i_db = 8'(i); tick();
    end
    chk("full_level", o_level, 16); chk("full_ovf", o_overflow, 0);
    chk("full_head_pc", o_pc, 16'h0100); chk("full_head_delta", o_delta, 2);
    i_ab = 16'h0110; i_db = 8'h10; i_ready = 1; tick();
    chk("fullpp_level", o_level, 16); chk("fullpp_ovf", o_overflow, 0);
    chk("fullpp_head", o_pc, 16'h0101);
    i_ab = 16'h0111; i_db = 8'h11; i_ready = 0; tick();
    chk("drop_level", o_level, 16); chk("drop_ovf", o_overflow, 1);
    chk("drop_head", o_pc, 16'h0101);
    i_sync = 0; i_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_pc", o_pc, 32'h0100 + 32'(i));
      chk("drain_delta", o_delta, 1);
      tick();
    end
    chk("drain_empty", o_valid, 0);

    // halt opcode, then clear
    i_ready = 0; i_sync = 1; i_ab = 16'h0020; i_db = 8'hff; tick();
    chk("halt_level", o_level, 1); chk("halt_flag", o_halt, 1);
    chk("halt_op", o_opcode, 8'hff); chk("halt_pc", o_pc, 16'h0020);
    i_ab = 16'h0022; i_db = 8'h01; tick();
    chk("halted_nopush", o_level, 1);
    chk("halted_cycle", o_cycle, 32'(cyc));
    i_sync = 0; i_clear = 1; tick(); i_clear = 0;
    chk("clr_level", o_level, 0); chk("clr_halt", o_halt, 0);
    chk("clr_ovf", o_overflow, 0); chk("clr_valid", o_valid, 0);

    // first decode after clear, then same-PC loop
    i_sync = 1; i_ab = 16'h0010; i_db = 8'h4c; exp_d = cyc; tick();
    chk("clr_delta", o_delta, 32'(exp_d)); chk("loop_first_flag", o_loop, 0);
    tick();
    chk("loop_level", o_level, 2); chk("loop_flag", o_loop, 1); chk("loop_nohalt", o_halt, 0);
    i_ab = 16'h0030; tick();
    chk("loop_nopush", o_level, 2); chk("loop_head", o_pc, 16'h0010);

    // enable gap between two decodes three enabled cycles apart
    i_sync = 0; i_clear = 1; i_ready = 1; tick(); i_clear = 0;
    chk("clr2_level", o_level, 0); chk("clr2_loop", o_loop, 0);
    i_sync = 1; i_ab = 16'h0040; i_db = 8'h01; tick();
    i_sync = 0; tick();
    i_enable = 0; i_sync = 1; i_ab = 16'h0099;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gap_cycle", o_cycle, 32'(cyc));
      chk("gap_nosample", o_level, 0);
    end
    i_enable = 1; i_sync = 0; tick();
    i_sync = 1; i_ab = 16'h0042; tick();
    chk("gap_pc", o_pc, 16'h0042); chk("gap_delta", o_delta, 3);

    // reset with entries queued
    i_ready = 0;
    for (int i = 0; i < 4; i++) begin
      i_ab = 16'h0050 + 16'(i); tick();
    end
    chk("pre_rst_level", o_level, 5);
    i_sync = 0;
    #2 rst_x = 0; cyc = 0;
    #1;
    chk("mrst_valid", o_valid, 0); chk("mrst_level", o_level, 0);
    chk("mrst_flags", {o_overflow, o_halt, o_loop}, 0);
    chk("mrst_head", {o_pc, o_opcode, o_delta}, 0); chk("mrst_cycle", o_cycle, 0);
    #3 rst_x = 1;
    tick();
    chk("post_rst_empty", o_level, 0);
    tick();
    i_sync = 1; i_ab = 16'h0060; i_db = 8'h02; exp_d = cyc; tick();
    chk("post_rst_pc", o_pc, 16'h0060); chk("post_rst_delta", o_delta, 32'(exp_d));
    chk("post_rst_delta2", o_delta, 2); chk("post_rst_level", o_level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
